// File: rtl/wb_mem_responder.sv
// Wishbone classic-cycle memory slave: word-addressed RAM with programmable wait states,
// byte-lane writes and error termination for out-of-range addresses.
module wb_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc_in,
    input  logic        stb_in,
    input  logic        we_in,
    input  logic [15:0] adr_in,
    input  logic [1:0]  sel_in,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        akn_out,
    output logic        err_out
);
    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [15:0] adr;
        logic [1:0]  sel;
        logic [15:0] data;
    } req_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    req_t        req_q, req;
    logic        in_range, enter_resp, do_write;
    logic [15:0] lane_mask;
    logic [AW-1:0] idx;
    logic [15:0] mem [DEPTH];

    // With zero wait states the access completes on the capture edge, so the live bus
    // inputs stand in for the latched copy while idle.
    always_comb begin
        req = req_q;
        if (state == IDLE) req = '{we: we_in, adr: adr_in, sel: sel_in, data: data_in};
    end

    assign in_range   = {16'd0, req.adr} < 32'(DEPTH);
    assign idx        = req.adr[AW-1:0];
    assign lane_mask  = {{8{req.sel[1]}}, {8{req.sel[0]}}};
    assign enter_resp = (state_nxt == RESP);
    assign do_write   = rst && enter_resp && in_range && req.we;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (cyc_in && stb_in) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                if (!cyc_in)          state_nxt = IDLE;
                else if (cnt == 4'd0) state_nxt = RESP;
                else                  cnt_nxt   = cnt - 4'd1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            req_q    <= '0;
            akn_out  <= 1'b0;
            err_out  <= 1'b0;
            data_out <= 16'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            if (state == IDLE) req_q <= req;
            akn_out  <= enter_resp && in_range;
            err_out  <= enter_resp && !in_range;
            data_out <= (enter_resp && in_range && !req.we) ? (mem[idx] & lane_mask) : 16'd0;
        end
    end

    // RAM is deliberately not reset; the write is gated by rst so a reset cancels it.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 2; b++) begin
                if (req.sel[b]) mem[idx][8*b +: 8] <= req.data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder: one instance with no wait states, one with three.
module tb_wb_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic [15:0] adr [2];
    logic [1:0]  sel [2];
    logic [15:0] dat [2];
    logic [15:0] dout[2];
    logic        akn [2];
    logic        err [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_mem_responder #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .cyc_in(cyc[0]), .stb_in(stb[0]), .we_in(we[0]),
        .adr_in(adr[0]), .sel_in(sel[0]), .data_in(dat[0]),
        .data_out(dout[0]), .akn_out(akn[0]), .err_out(err[0])
    );

    wb_mem_responder #(.DEPTH(256), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .rst(rst), .cyc_in(cyc[1]), .stb_in(stb[1]), .we_in(we[1]),
        .adr_in(adr[1]), .sel_in(sel[1]), .data_in(dat[1]),
        .data_out(dout[1]), .akn_out(akn[1]), .err_out(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus access; lat counts posedges from the capture edge up to the response.
    task automatic access(input int d, input logic w, input logic [15:0] a, input logic [1:0] s,
                          input logic [15:0] wd, output int lat, output logic ack,
                          output logic er, output logic [15:0] rd, output logic aft);
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dat[d] = wd;
        lat = 0;
        while (lat < 30) begin
            @(posedge clk); #1;
            lat++;
            if (akn[d] || err[d]) break;
        end
        ack = akn[d]; er = err[d]; rd = dout[d];
        cyc[d] = 1'b0; stb[d] = 1'b0;
        @(posedge clk); #1;
        aft = akn[d] | err[d];
    endtask

    int          lat;
    logic        ack, er, aft, seen;
    logic [15:0] rd;

    initial begin
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 0; stb[i] = 0; we[i] = 0; adr[i] = 0; sel[i] = 0; dat[i] = 0;
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_akn0", 32'(akn[0]), 0);
        chk("rst_err0", 32'(err[0]), 0);
        chk("rst_dout0", 32'(dout[0]), 0);
        chk("rst_akn1", 32'(akn[1]), 0);
        chk("rst_dout1", 32'(dout[1]), 0);
        @(negedge clk); rst = 1'b1;

        // zero wait states: write then read back
        access(0, 1, 16'd5, 2'b11, 16'hA5C3, lat, ack, er, rd, aft);
        chk("t1_wr_lat", lat, 1);
        chk("t1_wr_ack", 32'(ack), 1);
        chk("t1_wr_dout", 32'(rd), 0);
        access(0, 0, 16'd5, 2'b11, 16'h0, lat, ack, er, rd, aft);
        chk("t1_rd_lat", lat, 1);
        chk("t1_rd_data", 32'(rd), 32'hA5C3);
        chk("t1_rd_pulse", 32'(aft), 0);

        // three wait states
        access(1, 1, 16'd0, 2'b11, 16'h1234, lat, ack, er, rd, aft);
        chk("t2_wr_lat", lat, 4);
        access(1, 0, 16'd0, 2'b11, 16'h0, lat, ack, er, rd, aft);
        chk("t2_rd_lat", lat, 4);
        chk("t2_rd_ack", 32'(ack), 1);
        chk("t2_rd_data", 32'(rd), 32'h1234);
        chk("t2_rd_pulse", 32'(aft), 0);

        // byte lanes
        access(0, 1, 16'd7, 2'b11, 16'hFFFF, lat, ack, er, rd, aft);
        access(0, 1, 16'd7, 2'b01, 16'h0000, lat, ack, er, rd, aft);
        chk("t3_wr_ack", 32'(ack), 1);
        access(0, 0, 16'd7, 2'b11, 16'h0, lat, ack, er, rd, aft);
        chk("t3_rd_sel11", 32'(rd), 32'hFF00);
        access(0, 0, 16'd7, 2'b10, 16'h0, lat, ack, er, rd, aft);
        chk("t3_rd_sel10", 32'(rd), 32'hFF00);
        access(0, 0, 16'd7, 2'b01, 16'h0, lat, ack, er, rd, aft);
        chk("t3_rd_sel01", 32'(rd), 32'h0000);
        access(0, 1, 16'd8, 2'b00, 16'hFFFF, lat, ack, er, rd, aft);
        chk("t3_sel00_ack", 32'(ack), 1);

        // address range
        access(0, 1, 16'd0, 2'b11, 16'h0011, lat, ack, er, rd, aft);
        access(0, 1, 16'h0100, 2'b11, 16'hBEEF, lat, ack, er, rd, aft);
        chk("t4_oor_err", 32'(er), 1);
        chk("t4_oor_akn", 32'(ack), 0);
        chk("t4_oor_lat", lat, 1);
        chk("t4_oor_pulse", 32'(aft), 0);
        access(0, 0, 16'd0, 2'b11, 16'h0, lat, ack, er, rd, aft);
        chk("t4_alias_data", 32'(rd), 32'h0011);
        access(0, 1, 16'd255, 2'b11, 16'h7E7E, lat, ack, er, rd, aft);
        chk("t4_top_ack", 32'(ack), 1);
        access(0, 0, 16'd255, 2'b11, 16'h0, lat, ack, er, rd, aft);
        chk("t4_top_data", 32'(rd), 32'h7E7E);
        access(0, 0, 16'hFFFF, 2'b11, 16'h0, lat, ack, er, rd, aft);
        chk("t4_ffff_err", 32'(er), 1);
        chk("t4_ffff_dout", 32'(rd), 0);

        // abort in the second wait cycle
        access(1, 1, 16'd3, 2'b11, 16'h5555, lat, ack, er, rd, aft);
        @(negedge clk);
        cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 16'd3; sel[1] = 2'b11; dat[1] = 16'hAAAA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc[1] = 0; stb[1] = 0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | akn[1] | err[1];
        end
        chk("t5_no_resp", 32'(seen), 0);
        access(1, 0, 16'd3, 2'b11, 16'h0, lat, ack, er, rd, aft);
        chk("t5_next_lat", lat, 4);
        chk("t5_adr3_data", 32'(rd), 32'h5555);

        // async reset while ack is high
        @(negedge clk);
        cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 16'd5; sel[0] = 2'b11;
        @(posedge clk); #1;
        chk("t6_pre_akn", 32'(akn[0]), 1);
        chk("t6_pre_data", 32'(dout[0]), 32'hA5C3);
        #1 rst = 1'b0;
        #1;
        chk("t6_async_akn", 32'(akn[0]), 0);
        chk("t6_async_data", 32'(dout[0]), 0);
        cyc[0] = 0; stb[0] = 0;
        @(negedge clk); rst = 1'b1;

        // reset mid-wait drops the write
        access(1, 1, 16'd9, 2'b11, 16'h9999, lat, ack, er, rd, aft);
        @(negedge clk);
        cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 16'd9; sel[1] = 2'b11; dat[1] = 16'h0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("t6_wait_akn", 32'(akn[1]), 0);
        chk("t6_wait_err", 32'(err[1]), 0);
        cyc[1] = 0; stb[1] = 0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        access(1, 0, 16'd9, 2'b11, 16'h0, lat, ack, er, rd, aft);
        chk("t6_post_lat", lat, 4);
        chk("t6_post_data", 32'(rd), 32'h9999);
        access(0, 0, 16'd5, 2'b11, 16'h0, lat, ack, er, rd, aft);
        chk("t6_ram_kept", 32'(rd), 32'hA5C3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
